mm_src_dma: RTL and testbench

- Upstream feeder for the matrix-multiply engine: a read DMA that fetches a contiguous block of 32-bit words from the user-project memory port and streams them in order on AXI-Stream into the mm ss_* port.
- Pulses mm_start to the engine at job start and reports completion to firmware-facing control logic.
- Holds a small credit-controlled FIFO, so variable memory read latency and downstream backpressure never drop or duplicate data.

---
 rtl/mm_src_dma_if.sv | 33 +++
 rtl/mm_src_dma.sv | 148 ++++++++++++++
 tb/tb_mm_src_dma.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_src_dma_if.sv
// Bundle of control, memory-read and AXI-Stream signals for the mm source DMA.
// The master modport is the DMA's view; slave is the surrounding system's view.
interface mm_src_dma_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pLEN_WIDTH  = 10
);
  logic                   dma_start;
  logic [pADDR_WIDTH-1:0] dma_base_addr;
  logic [pLEN_WIDTH-1:0]  dma_len;
  logic                   dma_busy;
  logic                   dma_done;
  logic                   mm_start;
  logic                   mem_rd_req;
  logic [pADDR_WIDTH-1:0] mem_rd_addr;
  logic                   mem_rd_ack;
  logic                   mem_rd_valid;
  logic [pDATA_WIDTH-1:0] mem_rd_data;
  logic                   sm_tvalid;
  logic [pDATA_WIDTH-1:0] sm_tdata;
  logic                   sm_tlast;
  logic                   sm_tready;

  modport master (
    input  dma_start, dma_base_addr, dma_len, mem_rd_ack, mem_rd_valid, mem_rd_data, sm_tready,
    output dma_busy, dma_done, mm_start, mem_rd_req, mem_rd_addr, sm_tvalid, sm_tdata, sm_tlast
  );

  modport slave (
    output dma_start, dma_base_addr, dma_len, mem_rd_ack, mem_rd_valid, mem_rd_data, sm_tready,
    input  dma_busy, dma_done, mm_start, mem_rd_req, mem_rd_addr, sm_tvalid, sm_tdata, sm_tlast
  );
endinterface

// File: rtl/mm_src_dma.sv
// Read DMA feeding the mm engine: fetches len contiguous words and streams them
// in order through a credit-controlled FIFO so reads can never overrun the buffer.
module mm_src_dma #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pLEN_WIDTH  = 10,
  parameter int pFIFO_DEPTH = 4
) (
  input logic           axis_clk,
  input logic           axis_rst,
  mm_src_dma_if.master  bus
);
  localparam int PW = $clog2(pFIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = pLEN_WIDTH + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(pFIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [pADDR_WIDTH-1:0] base_q, base_d;
  logic [NW-1:0]          len_q, len_d;
  logic [NW-1:0]          issued_q, issued_d;
  logic [NW-1:0]          sent_q, sent_d;
  logic [CW-1:0]          outst_q, outst_d;
  logic [CW-1:0]          count_q, count_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic                   req_q, req_d;
  logic [pADDR_WIDTH-1:0] addr_q, addr_d;
  logic                   mm_start_q, mm_start_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [pDATA_WIDTH-1:0] fifo_mem [pFIFO_DEPTH];

  logic          issue_fire, ret_fire, pop, fifo_nempty, last_beat;
  logic [CW:0]   credits_used;

  assign fifo_nempty = (count_q != '0);
  assign issue_fire  = req_q & bus.mem_rd_ack;
  // Returns are only accepted while a job runs, so stale data after reset is dropped.
  assign ret_fire    = (state_q == S_RUN) & bus.mem_rd_valid;
  assign pop         = fifo_nempty & bus.sm_tready;
  assign last_beat   = (sent_q == len_q - NW'(1));

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    issued_d   = issued_q;
    sent_d     = sent_q;
    outst_d    = outst_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mm_start_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.dma_start) begin
          base_d   = bus.dma_base_addr & ~pADDR_WIDTH'(3);
          len_d    = NW'(bus.dma_len);
          issued_d = '0;
          sent_d   = '0;
          outst_d  = '0;
          count_d  = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          if (bus.dma_len != '0) begin
            state_d    = S_RUN;
            mm_start_d = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        issued_d = issued_q + NW'(issue_fire);
        outst_d  = outst_q + CW'(issue_fire) - CW'(ret_fire);
        count_d  = count_q + CW'(ret_fire) - CW'(pop);
        if (ret_fire) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          sent_d   = sent_q + NW'(1);
          if (last_beat) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Request is registered from next-cycle occupancy; a pending request never
    // drops because un-acked cycles can only shrink outstanding + buffered.
    credits_used = {1'b0, outst_d} + {1'b0, count_d};
    req_d  = (state_d == S_RUN) && (issued_d < len_d) && (credits_used < DEPTH_C);
    addr_d = base_d + pADDR_WIDTH'({issued_d, 2'b00});
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      outst_q    <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      mm_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      outst_q    <= outst_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      mm_start_q <= mm_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (ret_fire) fifo_mem[wr_ptr_q] <= bus.mem_rd_data;
  end

  assign bus.dma_busy    = busy_q;
  assign bus.dma_done    = done_q;
  assign bus.mm_start    = mm_start_q;
  assign bus.mem_rd_req  = req_q;
  assign bus.mem_rd_addr = addr_q;
  assign bus.sm_tvalid   = fifo_nempty;
  assign bus.sm_tdata    = fifo_nempty ? fifo_mem[rd_ptr_q] : '0;
  assign bus.sm_tlast    = fifo_nempty & last_beat;
endmodule

// File: tb/tb_mm_src_dma.sv
// Randomized bench for mm_src_dma: a memory model and stream monitor check every
// address and beat against expectations queued when each job is started.
module tb_mm_src_dma;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LW = 10;
  localparam int DEPTH = 4;

  logic axis_clk = 1'b0;
  logic axis_rst = 1'b1;

  mm_src_dma_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pLEN_WIDTH(LW)) bus ();

  mm_src_dma #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pLEN_WIDTH(LW), .pFIFO_DEPTH(DEPTH)) dut (
    .axis_clk (axis_clk),
    .axis_rst (axis_rst),
    .bus      (bus)
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct packed {logic [DW-1:0] data; logic last;} beat_t;
  typedef struct {logic [AW-1:0] addr; int due;} pend_t;

  beat_t          sb_q[$];
  logic [AW-1:0]  exp_addr_q[$];
  pend_t          pend_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int issued_cnt = 0, beat_cnt = 0;
  int stall_cnt = 0, stale_cnt = 0;
  int ack_pct = 100, lat_min = 1, lat_max = 1, rdy_mode = 0;
  logic [31:0] salt = 32'h0;
  int mm_cnt = 0, mm_cyc = 0, done_cyc = 0, last_beat_cyc = 0, start_cyc = 0, cur_len = 0;
  bit done_seen = 0, busy_at_mm = 0, busy_at_done = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a, input logic [31:0] s);
    return (32'(a) * 32'h9E37_79B1) ^ s;
  endfunction

  function automatic logic [63:0] outs_vec();
    return 64'({bus.mem_rd_req, bus.mem_rd_addr, bus.sm_tvalid, bus.sm_tdata, bus.sm_tlast,
                bus.dma_busy, bus.dma_done, bus.mm_start});
  endfunction

  initial forever begin
    @(posedge axis_clk);
    cyc++;
  end

  // Downstream ready pattern: 0 always, 1 random, 2 toggling, else held low.
  initial begin
    bus.sm_tready = 1'b0;
    forever begin
      @(negedge axis_clk);
      case (rdy_mode)
        0:       bus.sm_tready = 1'b1;
        1:       bus.sm_tready = 1'($urandom_range(0, 1));
        2:       bus.sm_tready = ~bus.sm_tready;
        default: bus.sm_tready = 1'b0;
      endcase
    end
  end

  // Memory model: random ack, in-order returns after a random latency >= 1.
  initial begin
    bit prev_stall;
    logic [AW-1:0] prev_addr;
    pend_t p;
    logic [AW-1:0] ea;
    prev_stall = 0;
    prev_addr = '0;
    bus.mem_rd_ack = 1'b0;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data = '0;
    forever begin
      @(negedge axis_clk);
      if (axis_rst) begin
        bus.mem_rd_ack = 1'b0;
        bus.mem_rd_valid = 1'b0;
        prev_stall = 0;
      end else begin
        if (prev_stall)
          check(bus.mem_rd_req && bus.mem_rd_addr == prev_addr, "req_hold",
                64'({bus.mem_rd_req, bus.mem_rd_addr}), 64'({1'b1, prev_addr}));
        check(issued_cnt - beat_cnt <= DEPTH, "credit_limit", 64'(issued_cnt - beat_cnt), 64'(DEPTH));
        if (stall_cnt > 0) begin
          bus.mem_rd_ack = 1'b0;
          stall_cnt--;
        end else begin
          bus.mem_rd_ack = ($urandom_range(0, 99) < ack_pct);
        end
        if (bus.mem_rd_req && bus.mem_rd_ack) begin
          if (exp_addr_q.size() == 0) begin
            check(1'b0, "unexpected_req", 64'(bus.mem_rd_addr), 64'(0));
          end else begin
            ea = exp_addr_q.pop_front();
            check(bus.mem_rd_addr == ea, "rd_addr", 64'(bus.mem_rd_addr), 64'(ea));
          end
          pend_q.push_back('{addr: bus.mem_rd_addr, due: cyc + int'($urandom_range(lat_min, lat_max))});
          issued_cnt++;
        end
        prev_stall = bus.mem_rd_req && !bus.mem_rd_ack;
        prev_addr = bus.mem_rd_addr;
        if (stale_cnt > 0) begin
          bus.mem_rd_valid = 1'b1;
          bus.mem_rd_data = 32'hDEAD_0000 | 32'(stale_cnt);
          stale_cnt--;
        end else if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
          p = pend_q.pop_front();
          bus.mem_rd_valid = 1'b1;
          bus.mem_rd_data = word_of(p.addr, salt);
        end else begin
          bus.mem_rd_valid = 1'b0;
        end
      end
    end
  end

  // Stream monitor: samples just before the rising edge and pops the scoreboard.
  initial begin
    bit prev_stall;
    logic [DW-1:0] prev_data;
    logic prev_last;
    beat_t e;
    prev_stall = 0;
    prev_data = '0;
    prev_last = 1'b0;
    forever begin
      @(negedge axis_clk);
      #2;
      if (axis_rst) begin
        prev_stall = 0;
      end else begin
        if (bus.mm_start) begin
          mm_cnt++;
          if (mm_cnt == 1) begin
            mm_cyc = cyc;
            busy_at_mm = bus.dma_busy;
          end
        end
        if (bus.dma_done) begin
          done_seen = 1;
          done_cyc = cyc;
          busy_at_done = bus.dma_busy;
        end
        if (prev_stall)
          check(bus.sm_tvalid && bus.sm_tdata == prev_data && bus.sm_tlast == prev_last, "stream_hold",
                64'({bus.sm_tvalid, bus.sm_tlast, bus.sm_tdata}), 64'({1'b1, prev_last, prev_data}));
        if (bus.sm_tvalid && bus.sm_tready) begin
          if (sb_q.size() == 0) begin
            check(1'b0, "unexpected_beat", 64'(bus.sm_tdata), 64'(0));
          end else begin
            e = sb_q.pop_front();
            check(bus.sm_tdata == e.data, "tdata", 64'(bus.sm_tdata), 64'(e.data));
            check(bus.sm_tlast == e.last, "tlast", 64'(bus.sm_tlast), 64'(e.last));
            if (e.last) last_beat_cyc = cyc;
          end
          $display("beat %0d data=0x%08h last=%0b cycle=%0d", beat_cnt, bus.sm_tdata, bus.sm_tlast, cyc);
          beat_cnt++;
        end
        prev_stall = bus.sm_tvalid && !bus.sm_tready;
        prev_data = bus.sm_tdata;
        prev_last = bus.sm_tlast;
      end
    end
  end

  task automatic start_job(input logic [AW-1:0] b, input int l);
    logic [AW-1:0] a;
    @(negedge axis_clk);
    salt = $urandom;
    mm_cnt = 0;
    done_seen = 0;
    issued_cnt = 0;
    beat_cnt = 0;
    cur_len = l;
    for (int i = 0; i < l; i++) begin
      a = AW'((int'(b) & ~3) + 4 * i);
      exp_addr_q.push_back(a);
      sb_q.push_back('{data: word_of(a, salt), last: (i == l - 1)});
    end
    bus.dma_start = 1'b1;
    bus.dma_base_addr = b;
    bus.dma_len = LW'(l);
    start_cyc = cyc;
    $display("job start base=0x%03h len=%0d cycle=%0d", b, l, cyc);
    @(negedge axis_clk);
    bus.dma_start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_seen && n < 3000) begin
      @(negedge axis_clk);
      n++;
    end
    check(done_seen, "done_timeout", 64'(n), 64'(0));
    if (done_seen) begin
      check(bus.dma_done == 1'b0 && bus.dma_busy == 1'b0, "done_one_cycle",
            64'({bus.dma_done, bus.dma_busy}), 64'(0));
      check(sb_q.size() == 0, "beats_left", 64'(sb_q.size()), 64'(0));
      check(exp_addr_q.size() == 0, "addrs_left", 64'(exp_addr_q.size()), 64'(0));
      check(beat_cnt == cur_len, "beat_count", 64'(beat_cnt), 64'(cur_len));
      check(mm_cnt == ((cur_len != 0) ? 1 : 0), "mm_start_count", 64'(mm_cnt), 64'((cur_len != 0) ? 1 : 0));
      check(busy_at_done == 1'b0, "busy_at_done", 64'(busy_at_done), 64'(0));
      if (cur_len != 0) begin
        check(mm_cyc == start_cyc + 1 && busy_at_mm, "mm_start_timing",
              64'(mm_cyc - start_cyc), 64'(1));
        check(done_cyc == last_beat_cyc + 1, "done_latency", 64'(done_cyc - last_beat_cyc), 64'(1));
      end else begin
        check(done_cyc == start_cyc + 1, "zero_len_done", 64'(done_cyc - start_cyc), 64'(1));
      end
      $display("job done len=%0d beats=%0d cycle=%0d", cur_len, beat_cnt, done_cyc);
    end
  endtask

  task automatic run_job(input logic [AW-1:0] b, input int l);
    start_job(b, l);
    wait_done();
  endtask

  initial begin
    int n;
    bus.dma_start = 1'b0;
    bus.dma_base_addr = '0;
    bus.dma_len = '0;
    repeat (3) @(negedge axis_clk);
    check(outs_vec() == 64'(0), "reset_outputs", outs_vec(), 64'(0));
    axis_rst = 1'b0;

    lat_min = 2; lat_max = 2; ack_pct = 100; rdy_mode = 0;
    run_job(12'h100, 4);

    lat_min = 1; lat_max = 3;
    rdy_mode = 2;
    start_job(12'h040, 8);
    repeat (12) @(negedge axis_clk);
    rdy_mode = 3;
    repeat (10) @(negedge axis_clk);
    rdy_mode = 0;
    wait_done();

    run_job(12'h300, 0);
    run_job(12'h3F0, 1);
    run_job(12'hFFC, 3);

    start_job(12'h500, 6);
    stall_cnt = 5;
    @(negedge axis_clk);
    bus.dma_start = 1'b1;
    bus.dma_base_addr = 12'h800;
    bus.dma_len = LW'(3);
    @(negedge axis_clk);
    bus.dma_start = 1'b0;
    wait_done();

    lat_min = 1; lat_max = 2;
    start_job(12'h200, 6);
    n = 0;
    while (beat_cnt < 2 && n < 500) begin
      @(negedge axis_clk);
      n++;
    end
    check(beat_cnt >= 2, "pre_reset_beats", 64'(beat_cnt), 64'(2));
    axis_rst = 1'b1;
    sb_q.delete();
    exp_addr_q.delete();
    pend_q.delete();
    issued_cnt = 0;
    beat_cnt = 0;
    @(negedge axis_clk);
    check(outs_vec() == 64'(0), "mid_job_reset_outputs", outs_vec(), 64'(0));
    @(negedge axis_clk);
    axis_rst = 1'b0;
    stale_cnt = 2;
    repeat (5) @(negedge axis_clk);
    check(beat_cnt == 0 && !bus.sm_tvalid, "stale_discarded", 64'({bus.sm_tvalid, 8'(beat_cnt)}), 64'(0));
    run_job(12'h020, 2);

    for (int j = 0; j < 6; j++) begin
      lat_min = 1;
      lat_max = $urandom_range(1, 6);
      ack_pct = $urandom_range(40, 100);
      rdy_mode = $urandom_range(0, 2);
      run_job(12'($urandom_range(0, 4095)), $urandom_range(1, 20));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
